// File: rtl/reel_pkg.sv
// Shared types and constants for the three-reel round controller.
// Reel bit order everywhere is {h, m, l} = bits [2:0].
package reel_pkg;

  typedef enum logic [2:0] {IDLE, SPIN3, SPIN2, SPIN1, DONE} round_state_t;

  localparam int REEL_W = 2;

  // Frozen-reel masks shown on the stopped output in each state
  localparam logic [2:0] STOP_IDLE  = 3'b111;
  localparam logic [2:0] STOP_SPIN3 = 3'b000;
  localparam logic [2:0] STOP_SPIN2 = 3'b100;
  localparam logic [2:0] STOP_SPIN1 = 3'b110;
  localparam logic [2:0] STOP_DONE  = 3'b111;

  // Stopped mask that a given state presents
  function automatic logic [2:0] stop_mask(round_state_t s);
    case (s)
      SPIN3:   stop_mask = STOP_SPIN3;
      SPIN2:   stop_mask = STOP_SPIN2;
      SPIN1:   stop_mask = STOP_SPIN1;
      DONE:    stop_mask = STOP_DONE;
      default: stop_mask = STOP_IDLE;
    endcase
  endfunction

  // One-hot reel that a press freezes when taken in state s
  function automatic logic [2:0] stop_sel(round_state_t s);
    case (s)
      SPIN3:   stop_sel = 3'b100;
      SPIN2:   stop_sel = 3'b010;
      SPIN1:   stop_sel = 3'b001;
      default: stop_sel = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Push-button debouncer: dout follows din only after DEB_CYCLES
// consecutive samples that differ from the current dout.
// Used by reel_stop_sequencer when BTN_DEBOUNCE_EN is defined.
module button_debouncer #(
  parameter int DEB_CYCLES = 20_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [CNT_W-1:0] cnt_reg;

  // Count disagreeing samples; any agreeing sample restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      dout    <= 1'b0;
    end else if (din == dout) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
      dout    <= din;
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/reel_stop_sequencer.sv
// Round controller for the three-reel random display.
// One press starts all reels, each further press stops one reel in
// h -> m -> l order; a win is flagged when all three stopped reels match.
// Optional build macro: BTN_DEBOUNCE_EN (inserts button_debouncer after
// the 2-flop synchroniser; without it only the synchroniser is used).
module reel_stop_sequencer
  import reel_pkg::*;
#(
  parameter int TICK_DIV   = 100_000,
  parameter int DEB_CYCLES = 20_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic [2:0] Ctrl,
  input  logic [7:0] rand_in,
  output logic [3:0] h,
  output logic [3:0] m,
  output logic [3:0] l,
  output logic [2:0] stopped,
  output logic       busy,
  output logic       win,
  output logic [7:0] rounds
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TICK_W-1:0]     tick_cnt_reg;
  logic                  tick;
  logic                  btn_meta_reg;
  logic                  btn_sync_reg;
  logic                  btn_cond;
  logic                  btn_prev_reg;
  logic                  press;
  logic [2:0]            stop_now;
  logic [3*REEL_W-1:0]   reel_bus;
  logic                  reels_equal;
  round_state_t          state_reg;
  logic                  win_pend_reg;
  logic                  unused_rand;

  assign unused_rand = ^rand_in[7:6];

  // Free-running reel-update divider; tick pulses on the last count
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt_reg <= '0;
    else if (tick) tick_cnt_reg <= '0;
    else           tick_cnt_reg <= tick_cnt_reg + 1'b1;
  end

  assign tick = (tick_cnt_reg == TICK_W'(TICK_DIV - 1));

  // Two-flop synchroniser for the asynchronous push-button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_reg <= 1'b0;
      btn_sync_reg <= 1'b0;
    end else begin
      btn_meta_reg <= button;
      btn_sync_reg <= btn_meta_reg;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  button_debouncer #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debouncer (
    .clk (clk),
    .rst (rst),
    .din (btn_sync_reg),
    .dout(btn_cond)
  );
`else
  logic unused_deb;
  assign unused_deb = (DEB_CYCLES < 1);
  assign btn_cond   = btn_sync_reg;
`endif

  // Previous conditioned level for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_prev_reg <= 1'b0;
    else     btn_prev_reg <= btn_cond;
  end

  assign press    = btn_cond & ~btn_prev_reg;
  // A reel being stopped this cycle must not take a coincident tick
  assign stop_now = press ? stop_sel(state_reg) : 3'b000;

  // One register per reel: reload on tick while spinning and not held
  for (genvar gi = 0; gi < 3; gi++) begin : g_reel
    logic [REEL_W-1:0] val_reg;
    logic              load;

    assign load = tick & ~stopped[gi] & ~stop_now[gi] & ~Ctrl[gi];

    // Reel value register
    always_ff @(posedge clk or posedge rst) begin
      if (rst)       val_reg <= '0;
      else if (load) val_reg <= rand_in[REEL_W*gi +: REEL_W];
    end

    assign reel_bus[REEL_W*gi +: REEL_W] = val_reg;
  end

  assign h = {{(4-REEL_W){1'b0}}, reel_bus[2*REEL_W +: REEL_W]};
  assign m = {{(4-REEL_W){1'b0}}, reel_bus[1*REEL_W +: REEL_W]};
  assign l = {{(4-REEL_W){1'b0}}, reel_bus[0 +: REEL_W]};

  assign reels_equal = (reel_bus[2*REEL_W +: REEL_W] == reel_bus[REEL_W +: REEL_W]) &&
                       (reel_bus[REEL_W +: REEL_W]   == reel_bus[0 +: REEL_W]);

  // Round FSM with registered stopped/busy/win/rounds outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      stopped      <= STOP_IDLE;
      busy         <= 1'b0;
      win          <= 1'b0;
      win_pend_reg <= 1'b0;
      rounds       <= 8'd0;
    end else begin
      // Reels are frozen in DONE, so the comparison one cycle later is stable
      win_pend_reg <= 1'b0;
      if (win_pend_reg) win <= reels_equal;
      if (press) begin
        case (state_reg)
          IDLE, DONE: begin
            state_reg <= SPIN3;
            stopped   <= stop_mask(SPIN3);
            busy      <= 1'b1;
            win       <= 1'b0;
          end
          SPIN3: begin
            state_reg <= SPIN2;
            stopped   <= stop_mask(SPIN2);
          end
          SPIN2: begin
            state_reg <= SPIN1;
            stopped   <= stop_mask(SPIN1);
          end
          SPIN1: begin
            state_reg    <= DONE;
            stopped      <= stop_mask(DONE);
            busy         <= 1'b0;
            win_pend_reg <= 1'b1;
            if (rounds != 8'hFF) rounds <= rounds + 8'd1;
          end
          default: begin
            state_reg <= IDLE;
            stopped   <= STOP_IDLE;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
